itlb_refill_ctrl: RTL

Sequences ITLB refills for instruction fetch. On an ITLB miss it performs an Sv32 two-level page-table walk over a single memory request/response port, then issues one fill write (tag + PPN + flags + victim way) into the ITLB arrays. It also handles fetch-side faults and TLB flush (sfence.vma) aborts. It sits between the fetch-stage ITLB lookup and the L1/L2 memory arbiter.

---
 rtl/itlb_refill_ctrl_pkg.sv | 54 +++++
 rtl/itlb_refill_ctrl_if.sv | 44 ++++
 rtl/itlb_refill_ctrl_pte_check.sv | 22 ++
 rtl/itlb_refill_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/itlb_refill_ctrl_pkg.sv
// Shared types for the ITLB refill walker: Sv32 PTE layout, walk states, widths.
// Superpage fills are enabled by defining ITLB_SUPERPAGE_EN; ITLB_ASSOC sets the default way count.
`ifndef ITLB_ASSOC
`define ITLB_ASSOC 4
`endif

package itlb_refill_ctrl_pkg;

  localparam int PTE_W   = 32;
  localparam int VPN_W   = 20;
  localparam int PPN_W   = 22;
  localparam int PADDR_W = 34;
  localparam int FLAGS_W = 8;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W_BIT   = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       rsw;
    logic             d;
    logic             a;
    logic             g;
    logic             u;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
  } sv32_pte_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L0_REQ  = 3'd3,
    ST_L0_WAIT = 3'd4,
    ST_FILL    = 3'd5,
    ST_FAULT   = 3'd6
  } itlb_walk_state_e;

  // Byte address of a 4-byte PTE inside the page-table page at base.
  function automatic logic [PADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] base,
                                                  input logic [9:0] idx);
    return {base, idx, 2'b00};
  endfunction

endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// Bundle between fetch, the refill walker, the memory arbiter and the ITLB arrays.
// Handshake: a request transfers on a cycle where valid and ready are both high; valid and
// its payload stay stable until then. Responses and fill/fault are single-cycle pulses.
interface itlb_refill_ctrl_if
  import itlb_refill_ctrl_pkg::*;
#(
  parameter int ASSOC = `ITLB_ASSOC
);
  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  logic               miss_valid;
  logic [31:0]        miss_vaddr;
  logic               miss_ready;
  logic [PPN_W-1:0]   satp_ppn;
  logic               flush;
  logic               mem_req_valid;
  logic [PADDR_W-1:0] mem_req_addr;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [PTE_W-1:0]   mem_resp_data;
  logic               fill_valid;
  logic [WAY_W-1:0]   fill_way;
  logic [VPN_W-1:0]   fill_vpn;
  logic [PPN_W-1:0]   fill_ppn;
  logic [FLAGS_W-1:0] fill_flags;
  logic               fill_super;
  logic               fault_valid;
  logic [31:0]        fault_vaddr;
  logic               busy;
  itlb_walk_state_e   dbg_state;

  modport master (
    input  miss_valid, miss_vaddr, satp_ppn, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_way, fill_vpn, fill_ppn,
           fill_flags, fill_super, fault_valid, fault_vaddr, busy, dbg_state
  );

  modport slave (
    output miss_valid, miss_vaddr, satp_ppn, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_way, fill_vpn, fill_ppn,
           fill_flags, fill_super, fault_valid, fault_vaddr, busy, dbg_state
  );

endinterface

// File: rtl/itlb_refill_ctrl_pte_check.sv
// Combinational Sv32 PTE decode: leaf detection, permission/format fault, superpage alignment.
module itlb_pte_check
  import itlb_refill_ctrl_pkg::*;
(
  input  sv32_pte_t pte,
  input  logic      level1,
  output logic      is_leaf,
  output logic      fault,
  output logic      misaligned_super
);

  logic unused_bits;
  assign unused_bits = ^{pte.rsw, pte.d, pte.g, pte.u};

  always_comb begin
    is_leaf          = pte.r | pte.x;
    // Instruction fetch needs X, and A is not updated in hardware, so both fault.
    fault            = !pte.v | (!pte.r & pte.w) | (is_leaf & (!pte.x | !pte.a));
    misaligned_super = level1 & is_leaf & (pte.ppn[9:0] != 10'd0);
  end

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB refill walker: Sv32 two-level page walk on one memory port, then one fill or fault pulse.
// Optional feature macro: ITLB_SUPERPAGE_EN (4 MiB leaves at level 1 fill instead of faulting).
module itlb_refill_ctrl
  import itlb_refill_ctrl_pkg::*;
#(
  parameter int ASSOC = `ITLB_ASSOC
) (
  input logic                i_clk,
  input logic                i_rst_n,
  itlb_refill_ctrl_if.master bus
);

  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  itlb_walk_state_e   state_q, state_d;
  logic [31:0]        vaddr_q, vaddr_d;
  logic               abort_q, abort_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [PADDR_W-1:0] req_addr_q, addr_d;
  logic               req_valid_q;
  logic               fill_valid_q;
  logic [WAY_W-1:0]   fill_way_q;
  logic [VPN_W-1:0]   fill_vpn_q;
  logic [PPN_W-1:0]   fill_ppn_q, fill_ppn_d;
  logic [FLAGS_W-1:0] fill_flags_q;
  logic               fault_valid_q;
  logic [31:0]        fault_vaddr_q;
  logic               busy_q;
`ifdef ITLB_SUPERPAGE_EN
  logic               fill_super_q, fill_super_d;
`endif

  sv32_pte_t resp_pte;
  logic      chk_leaf, chk_fault, chk_misaligned;

  assign resp_pte = sv32_pte_t'(bus.mem_resp_data);

  itlb_pte_check u_pte_check (
    .pte              (resp_pte),
    .level1           (state_q == ST_L1_WAIT),
    .is_leaf          (chk_leaf),
    .fault            (chk_fault),
    .misaligned_super (chk_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    vaddr_d    = vaddr_q;
    abort_d    = abort_q;
    victim_d   = victim_q;
    addr_d     = req_addr_q;
    fill_ppn_d = resp_pte.ppn;
`ifdef ITLB_SUPERPAGE_EN
    fill_super_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (bus.flush) begin
          victim_d = '0;
        end else if (bus.miss_valid) begin
          vaddr_d = bus.miss_vaddr;
          addr_d  = pte_addr(bus.satp_ppn, bus.miss_vaddr[31:22]);
          state_d = ST_L1_REQ;
        end
      end
      // A flush cannot withdraw an offered request; it only marks the walk for discard.
      ST_L1_REQ, ST_L0_REQ: begin
        if (bus.flush) abort_d = 1'b1;
        if (bus.mem_req_ready) state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
      end
      ST_L1_WAIT: begin
        if (bus.flush) abort_d = 1'b1;
        if (bus.mem_resp_valid) begin
          abort_d = 1'b0;
          if (abort_q || bus.flush) begin
            state_d = ST_IDLE;
          end else if (chk_fault) begin
            state_d = ST_FAULT;
          end else if (!chk_leaf) begin
            addr_d  = pte_addr(resp_pte.ppn, vaddr_q[21:12]);
            state_d = ST_L0_REQ;
          end else begin
`ifdef ITLB_SUPERPAGE_EN
            if (chk_misaligned) begin
              state_d = ST_FAULT;
            end else begin
              state_d      = ST_FILL;
              fill_super_d = 1'b1;
              fill_ppn_d   = {resp_pte.ppn[21:10], vaddr_q[21:12]};
            end
`else
            state_d = ST_FAULT;
`endif
          end
        end
      end
      ST_L0_WAIT: begin
        if (bus.flush) abort_d = 1'b1;
        if (bus.mem_resp_valid) begin
          abort_d = 1'b0;
          if (abort_q || bus.flush)        state_d = ST_IDLE;
          else if (chk_fault || !chk_leaf) state_d = ST_FAULT;
          else                             state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        abort_d  = 1'b0;
        victim_d = (victim_q == WAY_W'(ASSOC - 1)) ? '0 : victim_q + WAY_W'(1);
        state_d  = ST_IDLE;
      end
      ST_FAULT: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      vaddr_q       <= '0;
      abort_q       <= 1'b0;
      victim_q      <= '0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      fill_valid_q  <= 1'b0;
      fill_way_q    <= '0;
      fill_vpn_q    <= '0;
      fill_ppn_q    <= '0;
      fill_flags_q  <= '0;
      fault_valid_q <= 1'b0;
      fault_vaddr_q <= '0;
      busy_q        <= 1'b0;
`ifdef ITLB_SUPERPAGE_EN
      fill_super_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      vaddr_q       <= vaddr_d;
      abort_q       <= abort_d;
      victim_q      <= victim_d;
      req_valid_q   <= (state_d == ST_L1_REQ) || (state_d == ST_L0_REQ);
      req_addr_q    <= addr_d;
      fill_valid_q  <= (state_d == ST_FILL);
      fault_valid_q <= (state_d == ST_FAULT);
      busy_q        <= (state_d != ST_IDLE);
      if (state_d == ST_FILL) begin
        fill_way_q   <= victim_q;
        fill_vpn_q   <= vaddr_q[31:12];
        fill_ppn_q   <= fill_ppn_d;
        fill_flags_q <= bus.mem_resp_data[FLAGS_W-1:0];
`ifdef ITLB_SUPERPAGE_EN
        fill_super_q <= fill_super_d;
`endif
      end
      if (state_d == ST_FAULT) fault_vaddr_q <= vaddr_q;
    end
  end

  assign bus.miss_ready    = (state_q == ST_IDLE) && !bus.flush;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_way      = fill_way_q;
  assign bus.fill_vpn      = fill_vpn_q;
  assign bus.fill_ppn      = fill_ppn_q;
  assign bus.fill_flags    = fill_flags_q;
  assign bus.fault_valid   = fault_valid_q;
  assign bus.fault_vaddr   = fault_vaddr_q;
  assign bus.busy          = busy_q;
  assign bus.dbg_state     = state_q;
`ifdef ITLB_SUPERPAGE_EN
  assign bus.fill_super    = fill_super_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = chk_misaligned;
  assign bus.fill_super    = 1'b0;
`endif

endmodule
